// File: rtl/jtu_pkg.sv
// Shared types and constants for the jump target unit.
package jtu_pkg;

  typedef enum logic [2:0] {
    OP_J    = 3'd0,
    OP_JAL  = 3'd1,
    OP_BR   = 3'd2,
    OP_JR   = 3'd3,
    OP_JALR = 3'd4,
    OP_RET  = 3'd5
  } jtu_op_e;

  // Link skips the delay slot: pc_plus4 + 4.
  localparam int LINK_OFS = 4;

  function automatic logic is_link_op(input logic [2:0] op);
    return (op == OP_JAL) || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/jtu_ras.sv
// Circular return-address stack; overwrites the oldest entry when full.
// Optional sticky overflow/underflow flags under JTU_RAS_FLAGS_EN.
module jtu_ras
  import jtu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              full
`ifdef JTU_RAS_FLAGS_EN
  ,
  output logic              ovf,
  output logic              unf
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  ptr_q;
  logic [PTR_W:0]    cnt_q;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FULL_CNT);
  // ptr_q is the next write slot, so the top lives one below it.
  assign top   = mem_q[ptr_q - PTR_W'(1)];

  always_ff @(posedge clk) begin
    if (rst_n && !flush && push) mem_q[ptr_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (push) begin
      ptr_q <= ptr_q + PTR_W'(1);
      if (!full) cnt_q <= cnt_q + (PTR_W+1)'(1);
    end else if (pop && !empty) begin
      ptr_q <= ptr_q - PTR_W'(1);
      cnt_q <= cnt_q - (PTR_W+1)'(1);
    end
  end

`ifdef JTU_RAS_FLAGS_EN
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (push && full)  ovf <= 1'b1;
      if (pop && empty)  unf <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/jump_target_unit.sv
// Pipelined jump/branch/register target unit with RAS return prediction.
// Define JTU_RAS_FLAGS_EN to expose sticky ras_ovf/ras_unf outputs.
module jump_target_unit
  import jtu_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int IDX_W     = 26,
  parameter int IMM_W     = 16,
  parameter int SHAMT     = 2,
  parameter int RAS_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] pc_plus4,
  input  logic [IDX_W-1:0]  instr_index,
  input  logic [IMM_W-1:0]  imm,
  input  logic [ADDR_W-1:0] rs_val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] target,
  output logic              predicted,
  output logic              ras_empty,
  output logic              ras_full
`ifdef JTU_RAS_FLAGS_EN
  ,
  output logic              ras_ovf,
  output logic              ras_unf
`endif
);

  if (ADDR_W < IDX_W + SHAMT) begin : g_chk_w
    $error("jump_target_unit: ADDR_W must be >= IDX_W+SHAMT");
  end
  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_chk_d
    $error("jump_target_unit: RAS_DEPTH must be a power of two >= 2");
  end

  logic              out_valid_q;
  logic [ADDR_W-1:0] target_q, target_d;
  logic              pred_q, pred_d;
  logic              accept;
  logic              push, pop;
  logic [ADDR_W-1:0] ras_top;
  logic [ADDR_W-1:0] jmp_tgt, br_tgt, hi_mask, link;
  logic signed [ADDR_W-1:0] imm_sx;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = rst_n && !flush && in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign target    = target_q;
  assign predicted = pred_q;

  // Region jump keeps the PC bits above the shifted index field.
  assign hi_mask = {ADDR_W{1'b1}} << (IDX_W + SHAMT);
  assign jmp_tgt = (pc_plus4 & hi_mask) | (ADDR_W'(instr_index) << SHAMT);
  assign imm_sx  = ADDR_W'($signed(imm));
  assign br_tgt  = pc_plus4 + ADDR_W'(imm_sx <<< SHAMT);
  assign link    = pc_plus4 + ADDR_W'(LINK_OFS);

  assign push = accept && is_link_op(op);
  assign pop  = accept && (op == OP_RET);

  always_comb begin
    target_d = rs_val;
    pred_d   = 1'b0;
    case (op)
      OP_J, OP_JAL:   target_d = jmp_tgt;
      OP_BR:          target_d = br_tgt;
      OP_JR, OP_JALR: target_d = rs_val;
      OP_RET: begin
        if (!ras_empty) begin
          target_d = ras_top;
          pred_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      target_q    <= '0;
      pred_q      <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      target_q    <= target_d;
      pred_q      <= pred_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  jtu_ras #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push),
    .pop       (pop),
    .push_data (link),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
`ifdef JTU_RAS_FLAGS_EN
    ,
    .ovf       (ras_ovf),
    .unf       (ras_unf)
`endif
  );

endmodule

// File: tb/tb_jump_target_unit.sv
// Self-checking bench for jump_target_unit: queue-based reference model plus directed literals.
module tb_jump_target_unit;
  import jtu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = 3'd0;
  logic [31:0] pc_plus4 = '0;
  logic [25:0] instr_index = '0;
  logic [15:0] imm = '0;
  logic [31:0] rs_val = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] target;
  logic        predicted;
  logic        ras_empty;
  logic        ras_full;
`ifdef JTU_RAS_FLAGS_EN
  logic        ras_ovf, ras_unf;
`endif

  jump_target_unit dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .pc_plus4(pc_plus4), .instr_index(instr_index), .imm(imm), .rs_val(rs_val),
    .out_valid(out_valid), .out_ready(out_ready),
    .target(target), .predicted(predicted),
    .ras_empty(ras_empty), .ras_full(ras_full)
`ifdef JTU_RAS_FLAGS_EN
    , .ras_ovf(ras_ovf), .ras_unf(ras_unf)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  // Reference model: the RAS is a plain queue, newest at the back.
  bit          m_valid = 0;
  logic [31:0] m_target = '0;
  bit          m_pred = 0;
  logic [31:0] m_ras[$];
  bit          m_ovf = 0, m_unf = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid = 0; m_target = '0; m_pred = 0; m_ras.delete(); m_ovf = 0; m_unf = 0;
      chk_en = 1;
    end else if (flush) begin
      m_valid = 0; m_ras.delete(); m_ovf = 0; m_unf = 0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      m_pred = 0;
      case (op)
        3'd0, 3'd1: m_target = (pc_plus4 & 32'hF000_0000) | ({6'b0, instr_index} * 4);
        3'd2:       m_target = pc_plus4 + 32'($signed(imm)) * 4;
        3'd5: begin
          if (m_ras.size() > 0) begin m_target = m_ras.pop_back(); m_pred = 1; end
          else begin m_target = rs_val; m_unf = 1; end
        end
        default:    m_target = rs_val;
      endcase
      if (op == 3'd1 || op == 3'd4) begin
        if (m_ras.size() == 8) begin void'(m_ras.pop_front()); m_ovf = 1; end
        m_ras.push_back(pc_plus4 + 32'd4);
      end
      m_valid = 1;
    end else if (out_ready) begin
      m_valid = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (out_valid !== m_valid || target !== m_target || predicted !== m_pred ||
          in_ready !== (!m_valid || out_ready) ||
          ras_empty !== (m_ras.size() == 0) || ras_full !== (m_ras.size() == 8)) begin
        failures++;
        $display("FAIL model t=%0t act v=%0b tgt=%h p=%0b rdy=%0b e=%0b f=%0b exp v=%0b tgt=%h p=%0b e=%0b f=%0b",
                 $time, out_valid, target, predicted, in_ready, ras_empty, ras_full,
                 m_valid, m_target, m_pred, m_ras.size() == 0, m_ras.size() == 8);
      end
`ifdef JTU_RAS_FLAGS_EN
      checks++;
      if (ras_ovf !== m_ovf || ras_unf !== m_unf) begin
        failures++;
        $display("FAIL flags t=%0t act ovf=%0b unf=%0b exp ovf=%0b unf=%0b",
                 $time, ras_ovf, ras_unf, m_ovf, m_unf);
      end
`endif
    end
  end

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [2:0] o, input logic [31:0] pc, input logic [25:0] idx,
                      input logic [15:0] im, input logic [31:0] rs);
    op = o; pc_plus4 = pc; instr_index = idx; imm = im; rs_val = rs;
    in_valid = 1; out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    lit("rst_valid", 32'(out_valid), 32'd0);
    lit("rst_target", target, 32'd0);
    lit("rst_empty", 32'(ras_empty), 32'd1);
    lit("rst_full", 32'(ras_full), 32'd0);
    rst_n = 1;
    idle(1);

    send(OP_J, 32'h1000_0004, 26'h100, 16'h0, 32'h0);
    lit("j_target", target, 32'h1000_0400);
    lit("j_valid", 32'(out_valid), 32'd1);
    send(OP_BR, 32'h0000_0100, 26'h0, 16'hFFFF, 32'h0);
    lit("br_neg", target, 32'h0000_00FC);
    send(OP_BR, 32'hFFFF_FFF0, 26'h0, 16'h7FFF, 32'h0);
    lit("br_wrap", target, 32'h0001_FFEC);
    send(OP_JR, 32'h0, 26'h0, 16'h0, 32'h0000_1234);
    lit("jr", target, 32'h0000_1234);

    send(OP_JAL, 32'h0000_0400, 26'h0, 16'h0, 32'h0);
    send(OP_RET, 32'h0, 26'h0, 16'h0, 32'h0);
    lit("ret_tgt", target, 32'h0000_0404);
    lit("ret_pred", 32'(predicted), 32'd1);
    send(OP_RET, 32'h0, 26'h0, 16'h0, 32'h0000_8000);
    lit("ret_empty_tgt", target, 32'h0000_8000);
    lit("ret_empty_pred", 32'(predicted), 32'd0);
`ifdef JTU_RAS_FLAGS_EN
    lit("unf", 32'(ras_unf), 32'd1);
`endif
    send(3'd7, 32'h0, 26'h0, 16'h0, 32'h0000_0ABC);
    lit("undef_op", target, 32'h0000_0ABC);
    lit("undef_empty", 32'(ras_empty), 32'd1);

    for (int i = 1; i <= 9; i++) begin
      send(OP_JAL, 32'(i) * 32'h100, 26'h0, 16'h0, 32'h0);
      if (i == 8) lit("full_at_8", 32'(ras_full), 32'd1);
    end
    lit("full_at_9", 32'(ras_full), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      send(OP_RET, 32'h0, 26'h0, 16'h0, 32'hDEAD_0000);
      lit("ras_order", target, 32'(10 - k) * 32'h100 + 32'd4);
    end
    lit("drained", 32'(ras_empty), 32'd1);
`ifdef JTU_RAS_FLAGS_EN
    lit("ovf", 32'(ras_ovf), 32'd1);
`endif

    send(OP_JR, 32'h0, 26'h0, 16'h0, 32'h0000_0055);
    op = OP_JR; rs_val = 32'h0000_0066; in_valid = 1; out_ready = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      lit("bp_ready", 32'(in_ready), 32'd0);
      lit("bp_hold", target, 32'h0000_0055);
    end
    out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    lit("bp_release", target, 32'h0000_0066);

    send(OP_JAL, 32'h0000_0200, 26'h40, 16'h0, 32'h0);
    lit("pre_flush_tgt", target, 32'h0000_0100);
    op = OP_JAL; pc_plus4 = 32'h0000_0300; in_valid = 1; flush = 1;
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    lit("flush_valid", 32'(out_valid), 32'd0);
    lit("flush_empty", 32'(ras_empty), 32'd1);
    lit("flush_keep_tgt", target, 32'h0000_0100);

    send(OP_JAL, 32'h0000_0500, 26'h0, 16'h0, 32'h0);
    op = OP_JAL; pc_plus4 = 32'h0000_0600; in_valid = 1; rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1; in_valid = 0;
    lit("midrst_valid", 32'(out_valid), 32'd0);
    lit("midrst_empty", 32'(ras_empty), 32'd1);

    for (int n = 0; n < 200; n++) begin
      op = 3'($urandom_range(0, 7));
      pc_plus4 = $urandom; instr_index = 26'($urandom); imm = 16'($urandom); rs_val = $urandom;
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 40) == 0);
      @(posedge clk); #1;
    end
    flush = 0; in_valid = 0; out_ready = 1;
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
